// File: rtl/corefifo_fwft_pipe.sv
// First-word-fall-through read adapter with credit-controlled prefetch buffer.
// Optional macro COREFIFO_FWFT_LEVEL_EN adds the registered pf_level occupancy port.
module corefifo_fwft_pipe #(
  parameter int DWIDTH    = 18,
  parameter int RAM_LAT   = 1,
  parameter int PF_DEPTH  = 4,
  parameter int READ_LOW  = 0,
  parameter int AE_THRESH = 1
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              flush,
  input  logic              fifo_empty,
  input  logic              fifo_aempty,
  output logic              fifo_rd_en,
  input  logic [DWIDTH-1:0] fifo_dout,
  input  logic              rd_en,
  output logic [DWIDTH-1:0] dout,
  output logic              dout_valid,
  output logic              empty,
  output logic              aempty,
  output logic              underflow
`ifdef COREFIFO_FWFT_LEVEL_EN
  ,
  output logic [4:0]        pf_level
`endif
);

  localparam int PW = $clog2(PF_DEPTH);

  generate
    if (RAM_LAT < 1 || RAM_LAT > 3) begin : g_bad_ram_lat
      $error("corefifo_fwft_pipe: RAM_LAT must be 1..3");
    end
    if (PF_DEPTH < RAM_LAT + 1 || PF_DEPTH > 16 || (PF_DEPTH & (PF_DEPTH - 1)) != 0) begin : g_bad_pf_depth
      $error("corefifo_fwft_pipe: PF_DEPTH must be a power of two in RAM_LAT+1..16");
    end
    if (AE_THRESH < 0 || AE_THRESH > PF_DEPTH) begin : g_bad_ae_thresh
      $error("corefifo_fwft_pipe: AE_THRESH must be 0..PF_DEPTH");
    end
  endgenerate

  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr;
  logic [4:0]         occ;
  logic [4:0]         occ_next;
  logic [RAM_LAT-1:0] tags;
  logic [1:0]         infl;
  logic               rd_active;
  logic               consume;
  logic               write;
  logic [DWIDTH-1:0]  mem [PF_DEPTH];

  assign rd_active = (READ_LOW != 0) ? !rd_en : rd_en;
  assign consume   = rd_active && dout_valid;
  // The oldest tag marks the cycle its read data sits on fifo_dout; a flush drops it.
  assign write     = tags[RAM_LAT-1] && !flush;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    infl = '0;
    for (int i = 0; i < RAM_LAT; i++) begin
      infl = infl + {1'b0, tags[i]};
    end
  end

  // Credit uses registered counts only: a consume this cycle frees a slot next cycle.
  assign fifo_rd_en = aresetn && !fifo_empty && !flush &&
                      (({1'b0, occ} + {4'b0, infl}) < 6'(PF_DEPTH));

  always_comb begin
    occ_next = occ;
    case ({write, consume})
      2'b10:   occ_next = occ + 5'd1;
      2'b01:   occ_next = occ - 5'd1;
      default: occ_next = occ;
    endcase
    if (flush) occ_next = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      occ        <= '0;
      tags       <= '0;
      dout_valid <= 1'b0;
      empty      <= 1'b1;
      underflow  <= 1'b0;
    end else begin
      occ        <= occ_next;
      dout_valid <= (occ_next != '0);
      empty      <= (occ_next == '0);
      underflow  <= rd_active && (occ == '0);
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        tags   <= '0;
      end else begin
        tags <= (tags << 1) | RAM_LAT'(fifo_rd_en);
        if (write)   wr_ptr <= wr_ptr + 1'b1;
        if (consume) rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // NOTE: the buffer is a small flop array and dout must read zero out of reset, so it is reset.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < PF_DEPTH; i++) mem[i] <= '0;
    end else if (write) begin
      mem[wr_ptr] <= fifo_dout;
    end
  end

  assign dout   = mem[rd_ptr];
  assign aempty = fifo_aempty || (occ <= 5'(AE_THRESH));

`ifdef COREFIFO_FWFT_LEVEL_EN
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) pf_level <= '0;
    else          pf_level <= occ_next;
  end
`endif

endmodule

// File: tb/tb_corefifo_fwft_pipe.sv
// Directed bench: instance a (RAM_LAT=2, active-high rd_en) covers reset, first word,
// backpressure and streaming; instance b (RAM_LAT=3, READ_LOW=1) covers flush and underflow.
module tb_corefifo_fwft_pipe;

  localparam int DW = 18;

  logic clk;
  logic aresetn;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- instance a: RAM_LAT=2, PF_DEPTH=4, active-high rd_en
  logic          a_flush, a_fifo_empty, a_fifo_rd_en, a_rd_en;
  logic          a_dout_valid, a_empty, a_aempty, a_underflow;
  logic [DW-1:0] a_fifo_dout, a_dout;
  logic [DW-1:0] a_pipe [2];
  int            a_avail;
  int            a_rptr;

  assign a_fifo_empty = (a_rptr >= a_avail);
  assign a_fifo_dout  = a_pipe[1];

  always @(posedge clk or negedge aresetn) begin
    if (!aresetn)          a_rptr <= 0;
    else if (a_fifo_rd_en) a_rptr <= a_rptr + 1;
  end

  always @(posedge clk) begin
    a_pipe[0] <= DW'(a_rptr + 1);
    a_pipe[1] <= a_pipe[0];
  end

  corefifo_fwft_pipe #(
    .DWIDTH(DW), .RAM_LAT(2), .PF_DEPTH(4), .READ_LOW(0), .AE_THRESH(1)
  ) u_dut_a (
    .clk(clk), .aresetn(aresetn), .flush(a_flush),
    .fifo_empty(a_fifo_empty), .fifo_aempty(1'b0), .fifo_rd_en(a_fifo_rd_en),
    .fifo_dout(a_fifo_dout), .rd_en(a_rd_en), .dout(a_dout),
    .dout_valid(a_dout_valid), .empty(a_empty), .aempty(a_aempty), .underflow(a_underflow)
  );

  // ---------------- instance b: RAM_LAT=3, PF_DEPTH=4, active-low rd_en
  logic          b_flush, b_fifo_empty, b_fifo_rd_en, b_rd_en;
  logic          b_dout_valid, b_empty, b_aempty, b_underflow;
  logic [DW-1:0] b_fifo_dout, b_dout;
  logic [DW-1:0] b_pipe [3];
  int            b_avail;
  int            b_rptr;

  assign b_fifo_empty = (b_rptr >= b_avail);
  assign b_fifo_dout  = b_pipe[2];

  always @(posedge clk or negedge aresetn) begin
    if (!aresetn)          b_rptr <= 0;
    else if (b_fifo_rd_en) b_rptr <= b_rptr + 1;
  end

  always @(posedge clk) begin
    b_pipe[0] <= DW'(b_rptr + 1);
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end

  corefifo_fwft_pipe #(
    .DWIDTH(DW), .RAM_LAT(3), .PF_DEPTH(4), .READ_LOW(1), .AE_THRESH(1)
  ) u_dut_b (
    .clk(clk), .aresetn(aresetn), .flush(b_flush),
    .fifo_empty(b_fifo_empty), .fifo_aempty(1'b0), .fifo_rd_en(b_fifo_rd_en),
    .fifo_dout(b_fifo_dout), .rd_en(b_rd_en), .dout(b_dout),
    .dout_valid(b_dout_valid), .empty(b_empty), .aempty(b_aempty), .underflow(b_underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    int gaps;
    int started;
    logic [DW-1:0] exp;

    aresetn = 1'b0;
    a_flush = 1'b0; a_rd_en = 1'b0; a_avail = 100;
    b_flush = 1'b0; b_rd_en = 1'b1; b_avail = 0;

    // Reset held for 3 cycles with the controller non-empty
    repeat (3) tick();
    check("rst_fifo_rd_en", a_fifo_rd_en, 0);
    check("rst_empty",      a_empty, 1);
    check("rst_dout_valid", a_dout_valid, 0);
    check("rst_dout",       a_dout, 0);
    check("rst_aempty",     a_aempty, 1);
    check("rst_underflow",  a_underflow, 0);
    check("rst_b_empty",    b_empty, 1);
    check("rst_b_dout",     b_dout, 0);

    // Cycle 0: release; first strobe issues immediately
    aresetn = 1'b1;
    #1;
    check("c0_fifo_rd_en", a_fifo_rd_en, 1);
    tick(); tick();
    check("c2_dout_valid", a_dout_valid, 0);
    tick();
    check("c3_dout_valid", a_dout_valid, 1);
    check("c3_dout",       a_dout, 1);
    check("c3_aempty",     a_aempty, 1);
    check("c3_fifo_rd_en", a_fifo_rd_en, 1);

    // Backpressure: four issues fill the credit, dout holds the head word
    tick();
    check("c4_aempty", a_aempty, 0);
    for (int c = 4; c <= 8; c++) begin
      check($sformatf("bp_fifo_rd_en_c%0d", c), a_fifo_rd_en, 0);
      check($sformatf("bp_dout_c%0d", c), a_dout, 1);
      if (c < 8) tick();
    end
    check("bp_issue_count", a_rptr, 4);

    // Streaming: rd_en held, 100 words in order with no gap after the first
    tick();
    a_rd_en = 1'b1;
    #1;
    got = 0; gaps = 0; started = 0; exp = 1;
    for (int c = 0; c < 400 && got < 100; c++) begin
      if (c != 0) tick();
      if (a_dout_valid) begin
        check("stream_word", a_dout, exp);
        exp++;
        got++;
        started = 1;
      end else if (started != 0) begin
        gaps++;
      end
    end
    check("stream_count", got, 100);
    check("stream_gaps", gaps, 0);
    tick();
    a_rd_en = 1'b0;
    #1;
    check("stream_drained_empty", a_empty, 1);
    check("stream_upstream_reads", a_rptr, 100);

    // Flush on b: one word lands, then a flush one cycle after the next issue
    tick();
    b_avail = 1;
    #1;
    check("fl_c0_fifo_rd_en", b_fifo_rd_en, 1);
    tick(); tick(); tick();
    check("fl_c3_dout_valid", b_dout_valid, 0);
    tick();
    check("fl_c4_dout_valid", b_dout_valid, 1);
    check("fl_c4_dout",       b_dout, 1);
    b_avail = 3;
    #1;
    check("fl_c4_fifo_rd_en", b_fifo_rd_en, 1);
    tick();
    b_flush = 1'b1;
    #1;
    check("fl_c5_fifo_rd_en_forced", b_fifo_rd_en, 0);
    tick();
    b_flush = 1'b0;
    #1;
    check("fl_c6_dout_valid", b_dout_valid, 0);
    check("fl_c6_empty",      b_empty, 1);
    tick(); tick();
    check("fl_c8_dropped", b_dout_valid, 0);
    tick();
    check("fl_c9_dropped", b_dout_valid, 0);
    tick();
    check("fl_c10_dout_valid", b_dout_valid, 1);
    check("fl_c10_dout",       b_dout, 3);

    // Consume word 3 (active-low), then rd_en while empty -> one-cycle underflow
    b_rd_en = 1'b0;
    tick();
    check("uf_empty",        b_empty, 1);
    check("uf_pre_underflow", b_underflow, 0);
    tick();
    b_rd_en = 1'b1;
    #1;
    check("uf_pulse", b_underflow, 1);
    check("uf_dout_valid", b_dout_valid, 0);
    tick();
    check("uf_pulse_end", b_underflow, 0);
    b_avail = 4;
    repeat (4) tick();
    check("uf_after_dout_valid", b_dout_valid, 1);
    check("uf_after_dout",       b_dout, 4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
